// File: rtl/airlock_ctrl_timed.sv
// Airlock interlock controller: sequences inner/outer doors and chamber pressure,
// with built-in fill/drain/wait timers, door-switch supervision and a sticky fault.
//
// state          | meaning
// RST_CHK      0 | both doors commanded open, waiting for an empty chamber
// DOOR_CHK     1 | waiting for both door switches to report closed
// PRESS_CHK    2 | choose DRAIN or CLOSED_LOW from chamber pressure
// CLOSED_LOW   3 | sealed at low pressure, waiting for a request
// CLOSED_HIGH  4 | sealed at high pressure
// FILL         5 | pumping up
// DRAIN        6 | pumping down
// WAIT         7 | settle time before the inner door opens
// IN_OPEN_CHK  8 | inner door commanded open, waiting for its switch
// IN_OPEN      9 | inner door open
// IN_CLOSE_CHK 10| inner door commanded closed, waiting for its switch
// OUT_OPEN_CHK 11| outer door commanded open, waiting for its switch
// OUT_OPEN     12| outer door open
// OUT_CLOSE_CHK13| outer door commanded closed, waiting for its switch
// FAULT        15| latched fault, left only through reset
module airlock_ctrl_timed #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FILL_CYCLES  = 250,
  parameter int unsigned DRAIN_CYCLES = 350,
  parameter int unsigned WAIT_CYCLES  = 250,
  parameter int unsigned SW_TIMEOUT   = 100
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       arrive_req,
  input  logic       leave_req,
  input  logic       person_present,
  input  logic       pressure_high,
  input  logic       inner_sw,
  input  logic       outer_sw,
  output logic       inner_door_cmd,
  output logic       outer_door_cmd,
  output logic       filling,
  output logic       draining,
  output logic       waiting,
  output logic       fault,
  output logic [3:0] state_code
);

  typedef enum logic [3:0] {
    RST_CHK       = 4'd0,
    DOOR_CHK      = 4'd1,
    PRESS_CHK     = 4'd2,
    CLOSED_LOW    = 4'd3,
    CLOSED_HIGH   = 4'd4,
    FILL          = 4'd5,
    DRAIN         = 4'd6,
    WAIT          = 4'd7,
    IN_OPEN_CHK   = 4'd8,
    IN_OPEN       = 4'd9,
    IN_CLOSE_CHK  = 4'd10,
    OUT_OPEN_CHK  = 4'd11,
    OUT_OPEN      = 4'd12,
    OUT_CLOSE_CHK = 4'd13,
    FAULT         = 4'd15
  } state_t;

  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST    = CNT_W'(SW_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             any_open;
  logic             sw_expired;

  assign any_open   = inner_sw | outer_sw;
  assign sw_expired = (cnt == SW_LAST);
  assign state_code = state;

  // Door-opening checks come first so they override timer and request exits.
  always_comb begin
    state_nxt = state;
    case (state)
      RST_CHK: begin
        if (!person_present) state_nxt = DOOR_CHK;
      end
      DOOR_CHK: begin
        if (!inner_sw && !outer_sw) state_nxt = PRESS_CHK;
        else if (sw_expired)        state_nxt = FAULT;
      end
      PRESS_CHK: begin
        state_nxt = pressure_high ? DRAIN : CLOSED_LOW;
      end
      CLOSED_LOW: begin
        if (any_open)        state_nxt = FAULT;
        else if (arrive_req) state_nxt = FILL;
        else if (leave_req)  state_nxt = WAIT;
      end
      CLOSED_HIGH: begin
        if (any_open)        state_nxt = FAULT;
        else if (arrive_req) state_nxt = OUT_OPEN_CHK;
        else                 state_nxt = DRAIN;
      end
      FILL: begin
        if (any_open)               state_nxt = FAULT;
        else if (cnt == FILL_LAST)  state_nxt = CLOSED_HIGH;
      end
      DRAIN: begin
        if (any_open)               state_nxt = FAULT;
        else if (cnt == DRAIN_LAST) state_nxt = CLOSED_LOW;
      end
      WAIT: begin
        if (any_open)               state_nxt = FAULT;
        else if (cnt == WAIT_LAST)  state_nxt = IN_OPEN_CHK;
      end
      IN_OPEN_CHK: begin
        if (inner_sw && !person_present) state_nxt = IN_OPEN;
        else if (sw_expired)             state_nxt = FAULT;
      end
      IN_OPEN: begin
        if (outer_sw)        state_nxt = FAULT;
        else if (!leave_req) state_nxt = IN_CLOSE_CHK;
      end
      IN_CLOSE_CHK: begin
        if (!inner_sw && !person_present) state_nxt = CLOSED_LOW;
        else if (sw_expired)              state_nxt = FAULT;
      end
      OUT_OPEN_CHK: begin
        if (outer_sw && !person_present) state_nxt = OUT_OPEN;
        else if (sw_expired)             state_nxt = FAULT;
      end
      OUT_OPEN: begin
        if (inner_sw)         state_nxt = FAULT;
        else if (!arrive_req) state_nxt = OUT_CLOSE_CHK;
      end
      OUT_CLOSE_CHK: begin
        if (!outer_sw && !person_present) state_nxt = CLOSED_HIGH;
        else if (sw_expired)              state_nxt = FAULT;
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = FAULT;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (nReset) begin
      state          <= RST_CHK;
      cnt            <= '0;
      inner_door_cmd <= 1'b1;
      outer_door_cmd <= 1'b1;
      filling        <= 1'b0;
      draining       <= 1'b0;
      waiting        <= 1'b0;
      fault          <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)  cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
      inner_door_cmd <= (state_nxt == RST_CHK) || (state_nxt == IN_OPEN_CHK) ||
                        (state_nxt == IN_OPEN);
      outer_door_cmd <= (state_nxt == RST_CHK) || (state_nxt == OUT_OPEN_CHK) ||
                        (state_nxt == OUT_OPEN);
      filling        <= (state_nxt == FILL);
      draining       <= (state_nxt == DRAIN);
      waiting        <= (state_nxt == WAIT);
      fault          <= (state_nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_airlock_ctrl_timed.sv
// Bench for airlock_ctrl_timed: directed vector table, hand-written timer/fault
// sequences, and randomized traffic compared against a reference model.
module tb_airlock_ctrl_timed;

  localparam int FILL_N  = 4;
  localparam int DRAIN_N = 6;
  localparam int WAIT_N  = 3;
  localparam int SWT_N   = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       arrive_req, leave_req, person_present, pressure_high, inner_sw, outer_sw;
  logic       inner_door_cmd, outer_door_cmd, filling, draining, waiting, fault;
  logic [3:0] state_code;

  int n_checks = 0;
  int n_fail   = 0;

  airlock_ctrl_timed #(
    .CNT_W(16), .FILL_CYCLES(FILL_N), .DRAIN_CYCLES(DRAIN_N),
    .WAIT_CYCLES(WAIT_N), .SW_TIMEOUT(SWT_N)
  ) dut (
    .clk(clk), .nReset(rst),
    .arrive_req(arrive_req), .leave_req(leave_req), .person_present(person_present),
    .pressure_high(pressure_high), .inner_sw(inner_sw), .outer_sw(outer_sw),
    .inner_door_cmd(inner_door_cmd), .outer_door_cmd(outer_door_cmd),
    .filling(filling), .draining(draining), .waiting(waiting), .fault(fault),
    .state_code(state_code)
  );

  always #5 clk = ~clk;

  // inputs packed as {rst, arrive, leave, person, press, inner_sw, outer_sw}
  typedef struct packed {
    logic [6:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [9:0] E(int s, int in_c, int out_c, int fl, int dr, int wt, int ft);
    logic [9:0] e;
    e = {s[3:0], in_c[0], out_c[0], fl[0], dr[0], wt[0], ft[0]};
    return e;
  endfunction

  function automatic vec_t mkv(logic [6:0] in, logic [9:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    return v;
  endfunction

  task automatic drive(input logic [6:0] v);
    {rst, arrive_req, leave_req, person_present, pressure_high, inner_sw, outer_sw} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] got;
    got = {state_code, inner_door_cmd, outer_door_cmd, filling, draining, waiting, fault};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got state=%0d in/out/fill/drain/wait/fault=%b, expected state=%0d in/out/fill/drain/wait/fault=%b",
               name, got[9:6], got[5:0], exp[9:6], exp[5:0]);
    end
  endtask

  task automatic go_closed_low();
    drive(7'b1000000);
    step();
    drive(7'b0000000);
    step(); step(); step();
    check("reach_closed_low", E(3, 0, 0, 0, 0, 0, 0));
  endtask

  // Reference model: state code, cycles already spent in it, door commands as latched events
  int ms, dwell;
  bit m_in, m_out;

  task automatic model_edge(input logic [6:0] v);
    bit r, a, l, p, pr, i, o, opened, tmo;
    int nx;
    {r, a, l, p, pr, i, o} = v;
    if (r) begin
      ms = 0; dwell = 0; m_in = 1; m_out = 1;
      return;
    end
    opened = i | o;
    tmo    = (dwell == SWT_N - 1);
    nx     = ms;
    case (ms)
      0:  if (!p) begin nx = 1; m_in = 0; m_out = 0; end
      1:  nx = (!i && !o) ? 2 : (tmo ? 15 : 1);
      2:  nx = pr ? 6 : 3;
      3:  nx = opened ? 15 : (a ? 5 : (l ? 7 : 3));
      4:  if (opened) nx = 15; else if (a) begin nx = 11; m_out = 1; end else nx = 6;
      5:  nx = opened ? 15 : (dwell == FILL_N - 1 ? 4 : 5);
      6:  nx = opened ? 15 : (dwell == DRAIN_N - 1 ? 3 : 6);
      7:  if (opened) nx = 15; else if (dwell == WAIT_N - 1) begin nx = 8; m_in = 1; end
      8:  nx = (i && !p) ? 9 : (tmo ? 15 : 8);
      9:  if (o) nx = 15; else if (!l) begin nx = 10; m_in = 0; end
      10: nx = (!i && !p) ? 3 : (tmo ? 15 : 10);
      11: nx = (o && !p) ? 12 : (tmo ? 15 : 11);
      12: if (i) nx = 15; else if (!a) begin nx = 13; m_out = 0; end
      13: nx = (!o && !p) ? 4 : (tmo ? 15 : 13);
      default: nx = 15;
    endcase
    if (nx == 15) begin m_in = 0; m_out = 0; end
    dwell = (nx == ms) ? dwell + 1 : 0;
    ms    = nx;
  endtask

  initial begin
    tbl[0]  = mkv(7'b1001000, E(0, 1, 1, 0, 0, 0, 0));
    tbl[1]  = mkv(7'b0001000, E(0, 1, 1, 0, 0, 0, 0));
    tbl[2]  = mkv(7'b0000000, E(1, 0, 0, 0, 0, 0, 0));
    tbl[3]  = mkv(7'b0000000, E(2, 0, 0, 0, 0, 0, 0));
    tbl[4]  = mkv(7'b0000000, E(3, 0, 0, 0, 0, 0, 0));
    tbl[5]  = mkv(7'b0000000, E(3, 0, 0, 0, 0, 0, 0));
    tbl[6]  = mkv(7'b0010000, E(7, 0, 0, 0, 0, 1, 0));
    tbl[7]  = mkv(7'b0010000, E(7, 0, 0, 0, 0, 1, 0));
    tbl[8]  = mkv(7'b0010000, E(7, 0, 0, 0, 0, 1, 0));
    tbl[9]  = mkv(7'b0010000, E(8, 1, 0, 0, 0, 0, 0));
    tbl[10] = mkv(7'b0010010, E(9, 1, 0, 0, 0, 0, 0));
    tbl[11] = mkv(7'b0010010, E(9, 1, 0, 0, 0, 0, 0));
    tbl[12] = mkv(7'b0000010, E(10, 0, 0, 0, 0, 0, 0));
    tbl[13] = mkv(7'b0000000, E(3, 0, 0, 0, 0, 0, 0));
    tbl[14] = mkv(7'b0110000, E(5, 0, 0, 1, 0, 0, 0));
    tbl[15] = mkv(7'b0110001, E(15, 0, 0, 0, 0, 0, 1));
    tbl[16] = mkv(7'b0101010, E(15, 0, 0, 0, 0, 0, 1));
    tbl[17] = mkv(7'b1000000, E(0, 1, 1, 0, 0, 0, 0));

    drive(7'b1000000);
    #2;
    for (int k = 0; k < 18; k++) begin
      drive(tbl[k].in);
      step();
      check($sformatf("vec%0d", k), tbl[k].exp);
    end

    // fill timing, outer door cycle, then drain timing
    go_closed_low();
    drive(7'b0100000);
    for (int k = 0; k < FILL_N; k++) begin
      step();
      check($sformatf("fill_cycle%0d", k), E(5, 0, 0, 1, 0, 0, 0));
    end
    step(); check("fill_to_closed_high", E(4, 0, 0, 0, 0, 0, 0));
    step(); check("out_open_chk", E(11, 0, 1, 0, 0, 0, 0));
    drive(7'b0100001);
    step(); check("out_open", E(12, 0, 1, 0, 0, 0, 0));
    drive(7'b0000000);
    step(); check("out_close_chk", E(13, 0, 0, 0, 0, 0, 0));
    step(); check("back_closed_high", E(4, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < DRAIN_N; k++) begin
      step();
      check($sformatf("drain_cycle%0d", k), E(6, 0, 0, 0, 1, 0, 0));
    end
    step(); check("drain_to_closed_low", E(3, 0, 0, 0, 0, 0, 0));

    // switch timeout in OUT_OPEN_CHK, fault stickiness, reset release
    go_closed_low();
    drive(7'b0100000);
    for (int k = 0; k < FILL_N + 1; k++) step();
    step(); check("tmo_enter", E(11, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < SWT_N - 1; k++) begin
      step();
      check($sformatf("tmo_wait%0d", k), E(11, 0, 1, 0, 0, 0, 0));
    end
    step(); check("tmo_fault", E(15, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 8; k++) begin
      drive({1'b0, 6'($urandom)});
      step();
      check($sformatf("fault_sticky%0d", k), E(15, 0, 0, 0, 0, 0, 1));
    end
    drive(7'b1000000);
    step(); check("fault_reset", E(0, 1, 1, 0, 0, 0, 0));

    // reset in the middle of DRAIN
    drive(7'b1000100);
    step();
    drive(7'b0000100);
    step(); step();
    step(); check("drain_entry", E(6, 0, 0, 0, 1, 0, 0));
    step(); check("drain_mid", E(6, 0, 0, 0, 1, 0, 0));
    drive(7'b1000100);
    step(); check("reset_mid_drain", E(0, 1, 1, 0, 0, 0, 0));

    // randomized traffic with a plant whose switches mostly follow the commands
    begin
      logic [6:0] v;
      bit r, a, l, p, pr, i, o;
      a = 0; l = 0; pr = 0;
      for (int c = 0; c < 3000; c++) begin
        r  = (c == 0) || ($urandom_range(0, 199) == 0) ||
             ((ms == 15) && ($urandom_range(0, 19) == 0));
        a  = a ^ ($urandom_range(0, 9) == 0);
        l  = l ^ ($urandom_range(0, 9) == 0);
        p  = ($urandom_range(0, 9) == 0);
        pr = pr ^ ($urandom_range(0, 15) == 0);
        i  = m_in  ^ ($urandom_range(0, 59) == 0);
        o  = m_out ^ ($urandom_range(0, 59) == 0);
        v  = {r, a, l, p, pr, i, o};
        drive(v);
        model_edge(v);
        step();
        check($sformatf("rand%0d", c),
              E(ms, int'(m_in), int'(m_out), int'(ms == 5), int'(ms == 6), int'(ms == 7), int'(ms == 15)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
